// File: rtl/tile_layer_mixer.sv
// Two-layer tile pixel serializer and priority mixer feeding the palette stage.
// Optional build macro TILE_MIXER_LAYER_MASK_EN adds the LAYER_EN[1:0] per-layer gate.
module tile_layer_mixer #(
  parameter logic [3:0] TRANSPARENT_PEN = 4'hF,
  parameter int         ATTR_BITS       = 8
) (
  input  logic                   CLK_6M,
  input  logic                   rst,
  input  logic                   HA2,
  input  logic                   HB2,
  input  logic [15:0]            GDA,
  input  logic [15:0]            GDB,
  input  logic [ATTR_BITS-1:0]   ATTRA,
  input  logic [ATTR_BITS-1:0]   ATTRB,
  input  logic [2:0]             PRIA,
  input  logic [2:0]             PRIB,
  input  logic                   FLIP,
  input  logic                   nBLANK,
`ifdef TILE_MIXER_LAYER_MASK_EN
  input  logic [1:0]             LAYER_EN,
`endif
  output logic [ATTR_BITS+3:0]   DOT,
  output logic                   OPAQUE,
  output logic                   LAYER
);

  logic [15:0]          sr_a, sr_b;
  logic [ATTR_BITS-1:0] ar_a, ar_b;
  logic [1:0]           sc_a, sc_b;
  logic [3:0]           pen_a, pen_b;
  logic [1:0]           layer_en;

  logic [ATTR_BITS+3:0] dot_nxt;
  logic                 opaque_nxt;
  logic                 layer_nxt;
  logic                 vis_a, vis_b;

  // Shifting drains the word toward the pen tap and refills with transparent pens,
  // so an underrun reads transparent without any extra state.
  function automatic logic [15:0] shift_word(input logic [15:0] sr, input logic flip);
    return flip ? {TRANSPARENT_PEN, sr[15:4]} : {sr[11:0], TRANSPARENT_PEN};
  endfunction

  function automatic logic [1:0] sat_inc(input logic [1:0] sc);
    return (sc == 2'd3) ? sc : sc + 2'd1;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let one layer's update race the mix stage.
  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      sr_a <= {4{TRANSPARENT_PEN}};
      sr_b <= {4{TRANSPARENT_PEN}};
      ar_a <= '0;
      ar_b <= '0;
      sc_a <= 2'd3;
      sc_b <= 2'd3;
    end else begin
      if (HA2) begin
        sr_a <= GDA;
        ar_a <= ATTRA;
        sc_a <= 2'd0;
      end else begin
        sr_a <= shift_word(sr_a, FLIP);
        sc_a <= sat_inc(sc_a);
      end
      if (HB2) begin
        sr_b <= GDB;
        ar_b <= ATTRB;
        sc_b <= 2'd0;
      end else begin
        sr_b <= shift_word(sr_b, FLIP);
        sc_b <= sat_inc(sc_b);
      end
    end
  end

  assign pen_a = FLIP ? sr_a[3:0] : sr_a[15:12];
  assign pen_b = FLIP ? sr_b[3:0] : sr_b[15:12];

`ifdef TILE_MIXER_LAYER_MASK_EN
  assign layer_en = LAYER_EN;
`else
  assign layer_en = 2'b11;
`endif

  assign vis_a = (pen_a != TRANSPARENT_PEN) && layer_en[0];
  assign vis_b = (pen_b != TRANSPARENT_PEN) && layer_en[1];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    dot_nxt    = '0;
    opaque_nxt = 1'b0;
    layer_nxt  = 1'b0;
    if (nBLANK) begin
      // Ties on priority go to layer A.
      if (vis_a && (!vis_b || PRIA >= PRIB)) begin
        dot_nxt    = {ar_a, pen_a};
        opaque_nxt = 1'b1;
      end else if (vis_b) begin
        dot_nxt    = {ar_b, pen_b};
        opaque_nxt = 1'b1;
        layer_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_6M) begin
    if (rst) begin
      DOT    <= '0;
      OPAQUE <= 1'b0;
      LAYER  <= 1'b0;
    end else begin
      DOT    <= dot_nxt;
      OPAQUE <= opaque_nxt;
      LAYER  <= layer_nxt;
    end
  end

endmodule

// File: tb/tb_tile_layer_mixer.sv
// Self-checking bench for tile_layer_mixer: directed scenarios plus randomized traffic
// compared against a pixel-age reference model.
module tb_tile_layer_mixer;

  localparam logic [3:0] TP = 4'hF;

  logic        CLK_6M = 1'b0;
  logic        rst = 1'b1;
  logic        HA2 = 1'b0, HB2 = 1'b0;
  logic [15:0] GDA = '0, GDB = '0;
  logic [7:0]  ATTRA = '0, ATTRB = '0;
  logic [2:0]  PRIA = '0, PRIB = '0;
  logic        FLIP = 1'b0;
  logic        nBLANK = 1'b1;
  logic [1:0]  LAYER_EN = 2'b11;
  logic [11:0] DOT;
  logic        OPAQUE;
  logic        LAYER;

  int n_tests = 0;
  int n_fails = 0;

  always #5 CLK_6M = ~CLK_6M;

  tile_layer_mixer #(.TRANSPARENT_PEN(TP), .ATTR_BITS(8)) dut (
    .CLK_6M (CLK_6M),
    .rst    (rst),
    .HA2    (HA2),
    .HB2    (HB2),
    .GDA    (GDA),
    .GDB    (GDB),
    .ATTRA  (ATTRA),
    .ATTRB  (ATTRB),
    .PRIA   (PRIA),
    .PRIB   (PRIB),
    .FLIP   (FLIP),
    .nBLANK (nBLANK),
`ifdef TILE_MIXER_LAYER_MASK_EN
    .LAYER_EN (LAYER_EN),
`endif
    .DOT    (DOT),
    .OPAQUE (OPAQUE),
    .LAYER  (LAYER)
  );

  // Reference model: each layer remembers its last word as 4 pixels and how many
  // edges have passed since it was loaded; pixel i shows i edges after the load.
  logic [3:0] m_pix  [2][4];
  logic [7:0] m_attr [2];
  int         m_age  [2];

  function automatic logic [3:0] model_pen(input int l);
    if (m_age[l] >= 4) return TP;
    return m_pix[l][FLIP ? 3 - m_age[l] : m_age[l]];
  endfunction

  // Computes the output expected after the coming edge, advances the model and the clock.
  task automatic tick(output logic [11:0] ed, output logic eo, output logic el);
    logic [3:0] pa, pb;
    logic       va, vb;
    logic [1:0] en;
`ifdef TILE_MIXER_LAYER_MASK_EN
    en = LAYER_EN;
`else
    en = 2'b11;
`endif
    pa = model_pen(0);
    pb = model_pen(1);
    va = (pa != TP) && en[0];
    vb = (pb != TP) && en[1];
    ed = '0; eo = 1'b0; el = 1'b0;
    if (!rst && nBLANK) begin
      if (va && (!vb || PRIA >= PRIB)) begin
        ed = {m_attr[0], pa}; eo = 1'b1;
      end else if (vb) begin
        ed = {m_attr[1], pb}; eo = 1'b1; el = 1'b1;
      end
    end
    if (rst) begin
      for (int l = 0; l < 2; l++) begin
        m_age[l] = 4; m_attr[l] = '0;
      end
    end else begin
      if (HA2) begin
        for (int i = 0; i < 4; i++) m_pix[0][i] = GDA[15 - 4*i -: 4];
        m_attr[0] = ATTRA; m_age[0] = 0;
      end else if (m_age[0] < 4) m_age[0]++;
      if (HB2) begin
        for (int i = 0; i < 4; i++) m_pix[1][i] = GDB[15 - 4*i -: 4];
        m_attr[1] = ATTRB; m_age[1] = 0;
      end else if (m_age[1] < 4) m_age[1]++;
    end
    @(posedge CLK_6M);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] ed; logic eo, el;
    rst = 1'b1; HA2 = 1'b1; GDA = 16'h1234; ATTRA = 8'h5A;
    for (int c = 0; c < 2; c++) begin
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== 12'h000 || OPAQUE !== 1'b0 || LAYER !== 1'b0) begin
        n_fails++;
        $display("FAIL reset cyc%0d: dot=%h op=%b lay=%b, expected 000/0/0", c, DOT, OPAQUE, LAYER);
      end
    end
    rst = 1'b0; HA2 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== ed || OPAQUE !== eo || LAYER !== el || OPAQUE !== 1'b0) begin
        n_fails++;
        $display("FAIL post_reset cyc%0d: dot=%h op=%b lay=%b, expected dot=%h op=%b lay=%b",
                 c, DOT, OPAQUE, LAYER, ed, eo, el);
      end
    end
  endtask

  task automatic test_serialize(input logic flip);
    logic [11:0] ed; logic eo, el;
    logic [11:0] first_exp;
    FLIP = flip; GDA = 16'h1234; ATTRA = 8'h5A; HB2 = 1'b0; nBLANK = 1'b1;
    first_exp = flip ? 12'h5A4 : 12'h5A1;
    for (int c = 0; c < 16; c++) begin
      HA2 = (c % 4 == 0);
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== ed || OPAQUE !== eo || LAYER !== el) begin
        n_fails++;
        $display("FAIL serialize flip=%b cyc%0d: dot=%h op=%b lay=%b, expected dot=%h op=%b lay=%b",
                 flip, c, DOT, OPAQUE, LAYER, ed, eo, el);
      end
      if (c == 1) begin
        n_tests++;
        if (DOT !== first_exp || OPAQUE !== 1'b1) begin
          n_fails++;
          $display("FAIL first_pixel flip=%b: dot=%h op=%b, expected dot=%h op=1", flip, DOT, OPAQUE, first_exp);
        end
      end
    end
    HA2 = 1'b0;
    for (int c = 0; c < 5; c++) tick(ed, eo, el);
    FLIP = 1'b0;
  endtask

  task automatic test_priority(input logic [2:0] prib);
    logic [11:0] ed; logic eo, el;
    GDA = 16'h1111; ATTRA = 8'h5A; GDB = 16'h2F22; ATTRB = 8'h33;
    PRIA = 3'd2; PRIB = prib; FLIP = 1'b0;
    HA2 = 1'b1; HB2 = 1'b1;
    tick(ed, eo, el);
    HA2 = 1'b0; HB2 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== ed || OPAQUE !== eo || LAYER !== el) begin
        n_fails++;
        $display("FAIL priority prib=%0d pix%0d: dot=%h op=%b lay=%b, expected dot=%h op=%b lay=%b",
                 prib, c, DOT, OPAQUE, LAYER, ed, eo, el);
      end
    end
  endtask

  task automatic test_underrun_reload();
    logic [11:0] ed; logic eo, el;
    logic [3:0] seq [6];
    GDA = 16'h1234; ATTRA = 8'h5A; PRIA = 3'd0; PRIB = 3'd0;
    HA2 = 1'b1; tick(ed, eo, el); HA2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== ed || OPAQUE !== eo || LAYER !== el || OPAQUE !== (c < 4)) begin
        n_fails++;
        $display("FAIL underrun cyc%0d: dot=%h op=%b lay=%b, expected dot=%h op=%b lay=%b",
                 c, DOT, OPAQUE, LAYER, ed, eo, el);
      end
    end
    seq = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8};
    HA2 = 1'b1; GDA = 16'h1234; tick(ed, eo, el);
    HA2 = 1'b0; tick(ed, eo, el);
    n_tests++;
    if (DOT !== 12'h5A1) begin
      n_fails++; $display("FAIL reload pix0: dot=%h, expected 5a1", DOT);
    end
    HA2 = 1'b1; GDA = 16'h5678; tick(ed, eo, el);
    HA2 = 1'b0;
    n_tests++;
    if (DOT !== 12'h5A2) begin
      n_fails++; $display("FAIL reload pix1: dot=%h, expected 5a2", DOT);
    end
    for (int c = 2; c < 6; c++) begin
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== {8'h5A, seq[c]} || DOT !== ed || OPAQUE !== 1'b1) begin
        n_fails++;
        $display("FAIL reload pix%0d: dot=%h op=%b, expected dot=%h op=1", c, DOT, OPAQUE, {8'h5A, seq[c]});
      end
    end
    for (int c = 0; c < 2; c++) tick(ed, eo, el);
  endtask

  task automatic test_blank();
    logic [11:0] ed; logic eo, el;
    GDA = 16'h1234; ATTRA = 8'h5A; HB2 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      HA2 = (c % 4 == 0);
      nBLANK = !(c >= 2 && c <= 4);
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== ed || OPAQUE !== eo || LAYER !== el) begin
        n_fails++;
        $display("FAIL blank cyc%0d: dot=%h op=%b lay=%b, expected dot=%h op=%b lay=%b",
                 c, DOT, OPAQUE, LAYER, ed, eo, el);
      end
    end
    HA2 = 1'b0; nBLANK = 1'b1;
    for (int c = 0; c < 5; c++) tick(ed, eo, el);
  endtask

  task automatic test_random(input logic flip);
    logic [11:0] ed; logic eo, el;
    FLIP = flip;
    for (int c = 0; c < 300; c++) begin
      HA2 = ($urandom_range(0, 3) == 0);
      HB2 = ($urandom_range(0, 3) == 0);
      GDA = 16'($urandom);
      GDB = 16'($urandom);
      if ($urandom_range(0, 1) == 1) GDA[11:8] = TP;
      if ($urandom_range(0, 1) == 1) GDB[7:4] = TP;
      ATTRA = 8'($urandom);
      ATTRB = 8'($urandom);
      if (c % 37 == 0) begin
        PRIA = 3'($urandom); PRIB = 3'($urandom);
      end
      nBLANK = ($urandom_range(0, 7) != 0);
`ifdef TILE_MIXER_LAYER_MASK_EN
      LAYER_EN = 2'($urandom);
`endif
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== ed || OPAQUE !== eo || LAYER !== el) begin
        n_fails++;
        $display("FAIL random flip=%b cyc%0d: dot=%h op=%b lay=%b, expected dot=%h op=%b lay=%b",
                 flip, c, DOT, OPAQUE, LAYER, ed, eo, el);
      end
    end
    HA2 = 1'b0; HB2 = 1'b0; nBLANK = 1'b1; LAYER_EN = 2'b11;
    for (int c = 0; c < 5; c++) tick(ed, eo, el);
    FLIP = 1'b0;
  endtask

`ifdef TILE_MIXER_LAYER_MASK_EN
  task automatic test_layer_mask();
    logic [11:0] ed; logic eo, el;
    GDA = 16'h1111; GDB = 16'h2222; ATTRA = 8'hA0; ATTRB = 8'hB0;
    PRIA = 3'd6; PRIB = 3'd1; LAYER_EN = 2'b11;
    HA2 = 1'b1; HB2 = 1'b1; tick(ed, eo, el);
    HA2 = 1'b0; HB2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) LAYER_EN = 2'b10;
      tick(ed, eo, el);
      n_tests++;
      if (DOT !== ed || OPAQUE !== eo || LAYER !== el || LAYER !== (c >= 1)) begin
        n_fails++;
        $display("FAIL layer_mask cyc%0d: dot=%h op=%b lay=%b, expected dot=%h op=%b lay=%b",
                 c, DOT, OPAQUE, LAYER, ed, eo, el);
      end
    end
    LAYER_EN = 2'b11;
    for (int c = 0; c < 3; c++) tick(ed, eo, el);
  endtask
`endif

  initial begin
    test_reset();
    test_serialize(1'b0);
    test_serialize(1'b1);
    test_priority(3'd5);
    test_priority(3'd2);
    test_underrun_reload();
    test_blank();
`ifdef TILE_MIXER_LAYER_MASK_EN
    test_layer_mask();
`endif
    test_random(1'b0);
    test_random(1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
